// File: rtl/tick_burst_gen.sv
// tick_burst_gen: emits a burst of registered single-cycle ticks at a programmed spacing, with start/busy/done/abort control.
// Optional continuous mode (count=0 runs until abort) is enabled by defining TICK_BURST_CONTINUOUS_EN.
module tick_burst_gen #(
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] count,
  input  logic [P-1:0] period,
  input  logic         abort,
  output logic         tick,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] remaining
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
`ifdef TICK_BURST_CONTINUOUS_EN
  localparam logic CONT_EN = 1'b1;
`else
  localparam logic CONT_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [P-1:0] s_q, s_d, cnt_q, cnt_d;
  logic [N-1:0] rem_q, rem_d;
  logic tick_q, tick_d, busy_q, busy_d, done_q, done_d, cont_q, cont_d;
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    cont_d  = cont_q;
    tick_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        s_d   = (period == '0) ? P'(1) : period;
        cnt_d = (period == '0) ? '0 : period - P'(1);
        // count=0 is an empty burst unless continuous mode is built in
        if (count != '0 || CONT_EN) begin
          state_d = RUN;
          tick_d  = 1'b1;
          busy_d  = 1'b1;
          rem_d   = (count == '0) ? '0 : count - N'(1);
          cont_d  = (count == '0);
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
          rem_d   = '0;
          cont_d  = 1'b0;
        end
      end
      RUN: if (abort) begin
        state_d = IDLE;
        rem_d   = '0;
        cont_d  = 1'b0;
      end else if (!cont_q && rem_q == '0) begin
        state_d = FIN;
        done_d  = 1'b1;
      end else begin
        busy_d = 1'b1;
        tick_d = (cnt_q == '0);
        cnt_d  = (cnt_q == '0) ? s_q - P'(1) : cnt_q - P'(1);
        rem_d  = (cnt_q == '0 && !cont_q) ? rem_q - N'(1) : rem_q;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      cont_q  <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      cont_q  <= cont_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;
endmodule

// File: tb/tb_tick_burst_gen.sv
// tb_tick_burst_gen: directed per-cycle checks of tick/busy/done/remaining against hand-computed masks.
module tb_tick_burst_gen;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] count = '0;
  logic [7:0] period = '0;
  logic tick, busy, done;
  logic [3:0] remaining;
  int total = 0, bad = 0;
  int rq[$];
  tick_burst_gen #(.N(4), .P(8)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .period(period),
    .abort(abort), .tick(tick), .busy(busy), .done(done), .remaining(remaining)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string nm, input int cnt, input int per, input int len,
                     input logic [31:0] tm, input logic [31:0] bm, input logic [31:0] dm,
                     input int ab_c, input int rs_c, input int st_c);
    count = 4'(cnt);
    period = 8'(per);
    start = 1'b1;
    for (int c = 1; c <= len; c++) begin
      step();
      chk($sformatf("%s c%0d tick", nm, c), int'(tick), int'(tm[c]));
      chk($sformatf("%s c%0d busy", nm, c), int'(busy), int'(bm[c]));
      chk($sformatf("%s c%0d done", nm, c), int'(done), int'(dm[c]));
      if (c - 1 < rq.size()) chk($sformatf("%s c%0d rem", nm, c), int'(remaining), rq[c-1]);
      abort = (c == ab_c);
      reset = (c == rs_c);
      start = (c == st_c);
      if (c == st_c) count = 4'd9;
    end
    abort = 1'b0;
    reset = 1'b0;
    start = 1'b0;
  endtask
  initial begin
    int n, last, dc;
    step();
    step();
    chk("rst tick", int'(tick), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst rem", int'(remaining), 0);
    reset = 1'b0;
    rq = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0};
    run("c4p3", 4, 3, 12, (1<<1)|(1<<4)|(1<<7)|(1<<10), 32'h0000_07FE, 1<<11, 0, 0, 0);
    rq = '{2, 1, 0, 0, 0, 0};
    run("c3p0", 3, 0, 6, 32'h0000_000E, 32'h0000_000E, 1<<4, 0, 0, 0);
`ifdef TICK_BURST_CONTINUOUS_EN
    rq = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run("cont", 0, 2, 9, (1<<1)|(1<<3)|(1<<5), 32'h0000_007E, 32'h0, 6, 0, 0);
`else
    rq = '{0, 0, 0};
    run("c0", 0, 5, 3, 32'h0, 32'h0, 1<<1, 0, 0, 0);
`endif
    rq = '{4, 4, 3, 3, 2, 2, 1, 1, 0, 0, 0};
    run("restart", 5, 2, 11, (1<<1)|(1<<3)|(1<<5)|(1<<7)|(1<<9), 32'h0000_03FE, 1<<10, 0, 0, 3);
    rq = '{7, 7, 6, 6, 5, 0, 0, 0, 0, 0};
    run("abort", 8, 2, 10, (1<<1)|(1<<3)|(1<<5), 32'h0000_003E, 32'h0, 5, 0, 0);
    rq = '{7, 6, 5, 4, 0, 0, 0, 0};
    run("reset", 8, 1, 8, 32'h0000_001E, 32'h0000_001E, 32'h0, 0, 4, 0);
    rq = '{14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0};
    run("c15p1", 15, 1, 17, 32'h0000_FFFE, 32'h0000_FFFE, 1<<16, 0, 0, 0);
    rq = {};
    n = 0;
    last = 0;
    dc = 0;
    count = 4'd2;
    period = 8'd255;
    start = 1'b1;
    for (int c = 1; c <= 258; c++) begin
      step();
      start = 1'b0;
      if (tick) begin
        n++;
        last = c;
      end
      if (done) dc = c;
    end
    chk("p255 ticks", n, 2);
    chk("p255 last tick", last, 256);
    chk("p255 done", dc, 257);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
